// File: rtl/seg7_pkg.sv
// Shared glyph constants and BCD-to-segment mapping for the seven-segment
// display drivers. Segment order is gfedcba, active-high (1 = segment lit).
package seg7_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1101111;
  localparam logic [6:0] GLYPH_E     = 7'b1111001;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  // Non-BCD nibbles (10..15) render as an unlit digit.
  function automatic logic [6:0] bcd_to_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-glyph decoder. The error request wins over both
// the nibble value and the leading-zero blank request.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       err,
  input  logic       blank,
  output logic [6:0] glyph
);

  // Select error glyph, suppressed digit, or the decoded BCD digit.
  always_comb begin
    glyph = GLYPH_BLANK;
    if (err) begin
      glyph = GLYPH_E;
    end else if (blank) begin
      glyph = GLYPH_BLANK;
    end else begin
      glyph = bcd_to_glyph(nibble);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: captures a packed BCD word on a load
// strobe and scans one digit per slot, with an all-off window at the start of
// each slot to avoid ghosting. Pin polarity is applied only at the outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    error_flag,
  input  logic                    blank_lz,
  output logic [6:0]              codeout,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [4*NUM_DIGITS-1:0] val_r;
  logic                    err_r;
  logic                    blz_r;
  logic [DIV_W-1:0]        div_r;
  logic [IDX_W-1:0]        idx_r;

  logic [3:0]              nib_s;
  logic [IDX_W-1:0]        msnz_s;
  logic                    lz_blank_s;
  logic                    blank_win_s;
  logic [NUM_DIGITS-1:0]   onehot_s;
  logic [6:0]              glyph_s;

  // Shadow registers: the display only ever reads captured state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_r <= {(4*NUM_DIGITS){1'b0}};
      err_r <= 1'b0;
      blz_r <= 1'b0;
    end else if (load) begin
      val_r <= value;
      err_r <= error_flag;
      blz_r <= blank_lz;
    end else begin
      val_r <= val_r;
      err_r <= err_r;
      blz_r <= blz_r;
    end
  end

  // Slot divider and digit index; index advances on the last cycle of a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= {DIV_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else if (div_r == DIV_LAST) begin
      div_r <= {DIV_W{1'b0}};
      idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
    end else begin
      div_r <= div_r + DIV_W'(1);
      idx_r <= idx_r;
    end
  end

  // Highest non-zero digit; digits above it are leading zeros. Digit 0 is
  // the floor so an all-zero value still shows a single "0".
  always_comb begin
    msnz_s = {IDX_W{1'b0}};
    for (int k = 1; k < NUM_DIGITS; k++) begin
      msnz_s = (val_r[4*k +: 4] != 4'd0) ? IDX_W'(k) : msnz_s;
    end
  end

  // Current-digit selection, suppression, blank window and one-hot enable.
  always_comb begin
    nib_s       = val_r[{idx_r, 2'b00} +: 4];
    lz_blank_s  = blz_r && (idx_r > msnz_s);
    blank_win_s = (32'(div_r) < BLANK_CYC);
    onehot_s    = {NUM_DIGITS{1'b0}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      onehot_s[k] = (idx_r == IDX_W'(k));
    end
  end

  seg7_glyph u_glyph (
    .nibble (nib_s),
    .err    (err_r),
    .blank  (lz_blank_s),
    .glyph  (glyph_s)
  );

  // Output registers; polarity applied here so "off" is always the idle pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codeout <= SEG_OFF;
      dig_sel <= DIG_OFF;
    end else if (blank_win_s) begin
      codeout <= SEG_OFF;
      dig_sel <= DIG_OFF;
    end else begin
      codeout <= glyph_s ^ SEG_OFF;
      dig_sel <= onehot_s ^ DIG_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: an active-high and an active-low instance share
// stimulus; a behavioural model derives the expected pins from elapsed cycles.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int SCAN  = 8;
  localparam int BLANK = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic        error_flag;
  logic        blank_lz;
  logic [6:0]  codeout;
  logic [3:0]  dig_sel;
  logic [6:0]  codeout_n;
  logic [3:0]  dig_sel_n;

  int total = 0;
  int bad   = 0;

  // Model state: shadows and rising edges seen since reset release.
  logic [15:0] m_val;
  logic        m_err;
  logic        m_blz;
  int          m_t;

  logic [6:0] gtab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                            7'b1111111, 7'b1101111, 7'b0000000, 7'b0000000,
                            7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SCAN), .BLANK_CYC(BLANK),
                     .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .error_flag(error_flag), .blank_lz(blank_lz),
    .codeout(codeout), .dig_sel(dig_sel));

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SCAN), .BLANK_CYC(BLANK),
                     .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_dut_inv (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .error_flag(error_flag), .blank_lz(blank_lz),
    .codeout(codeout_n), .dig_sel(dig_sel_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%b exp=%b", tag, m_t, got, exp);
    end
  endtask

  // Expected {codeout, dig_sel} (active-high) for the slot state reached after t edges.
  function automatic logic [10:0] model_out(int t);
    int         slot_pos;
    int         digit;
    logic [6:0] c;
    logic [3:0] d;
    slot_pos = t % SCAN;
    digit    = (t / SCAN) % ND;
    if (slot_pos < BLANK) return 11'd0;
    d = 4'(1 << digit);
    if (m_err)
      c = 7'b1111001;
    else if (m_blz && digit > 0 && (m_val >> (4 * digit)) == 16'd0)
      c = 7'b0000000;
    else
      c = gtab[4'((m_val >> (4 * digit)) & 16'hF)];
    return {c, d};
  endfunction

  // One clock: predict from pre-edge state, update model, check at negedge.
  task automatic tick();
    logic [10:0] e;
    @(posedge clk);
    if (!rst_n) begin
      e = 11'd0;
    end else begin
      e = model_out(m_t);
      if (load) begin
        m_val = value;
        m_err = error_flag;
        m_blz = blank_lz;
      end
      m_t++;
    end
    @(negedge clk);
    check("codeout",   {9'd0, codeout},   {9'd0, e[10:4]});
    check("dig_sel",   {12'd0, dig_sel},  {12'd0, e[3:0]});
    check("codeout_n", {9'd0, codeout_n}, {9'd0, ~e[10:4]});
    check("dig_sel_n", {12'd0, dig_sel_n}, {12'd0, ~e[3:0]});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_val(input logic [15:0] v, input logic e, input logic b);
    value = v; error_flag = e; blank_lz = b; load = 1'b1;
    tick();
    load = 1'b0;
    value = 16'($urandom);
    error_flag = 1'($urandom);
    blank_lz = 1'($urandom);
  endtask

  // Assert reset at a negedge, check the asynchronous clear, hold, release.
  task automatic pulse_reset(input int cycles);
    rst_n = 1'b0;
    m_t = 0; m_val = 16'd0; m_err = 1'b0; m_blz = 1'b0;
    #1;
    check("rst_async_code",   {9'd0, codeout},    16'h0000);
    check("rst_async_dig",    {12'd0, dig_sel},   16'h0000);
    check("rst_async_code_n", {9'd0, codeout_n},  16'h007F);
    check("rst_async_dig_n",  {12'd0, dig_sel_n}, 16'h000F);
    for (int i = 0; i < cycles; i++) begin
      load = 1'b1; value = 16'($urandom); error_flag = 1'($urandom);
      tick();
    end
    load = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = 16'd0; error_flag = 1'b0; blank_lz = 1'b0;
    m_t = 0; m_val = 16'd0; m_err = 1'b0; m_blz = 1'b0;

    // Reset held with load activity that must be ignored.
    for (int i = 0; i < 5; i++) begin
      load = 1'b1; value = 16'($urandom); error_flag = 1'b1;
      tick();
    end
    load = 1'b0; error_flag = 1'b0;
    rst_n = 1'b1;
    run(SCAN * ND);

    // Directed patterns, each followed by a full frame.
    load_val(16'h1234, 1'b0, 1'b0); run(SCAN * ND + 3);
    load_val(16'h0070, 1'b0, 1'b1); run(SCAN * ND + 3);
    load_val(16'h0000, 1'b0, 1'b1); run(SCAN * ND + 3);
    load_val(16'($urandom), 1'b1, 1'($urandom)); run(SCAN * ND + 3);
    load_val(16'hA5F9, 1'b0, 1'b0); run(SCAN * ND + 3);
    load_val(16'h0008, 1'b0, 1'b0); run(SCAN * ND + 3);

    // Mid-slot load followed by back-to-back loads (last wins).
    run(4);
    load_val(16'h9876, 1'b0, 1'b0); run(5);
    load_val(16'h1111, 1'b0, 1'b0);
    load_val(16'h0305, 1'b0, 1'b1); run(SCAN * ND);

    // Reset pulse during slot 2.
    while (!(((m_t / SCAN) % ND) == 2 && (m_t % SCAN) == 4)) tick();
    pulse_reset(3);
    run(SCAN * ND + 2);

    // Randomized loads at arbitrary points, live inputs wiggling in between.
    for (int i = 0; i < 600; i++) begin
      value = 16'($urandom);
      error_flag = ($urandom_range(0, 7) == 0);
      blank_lz = 1'($urandom);
      if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
      if ($urandom_range(0, 5) == 0) value = value & 16'h000F;
      load = ($urandom_range(0, 9) == 0);
      tick();
      load = 1'b0;
      if (i == 300) begin
        pulse_reset(2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
